// File: rtl/secuenciador_alu.sv
// Single-button sequencer for the 8-bit calculator ALU: debounces one push-button
// and steps through loading A, B and the opcode, then latches the ALU result.
module secuenciador_alu #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] entrada,
  input  logic       boton_enter,
  input  logic [7:0] alu_rdo,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [5:0] op,
  output logic [7:0] rdo_reg,
  output logic       carry_reg,
  output logic       zero_reg,
  output logic       listo,
  output logic [2:0] estado
);

  // The counter only has to hold 0..DEBOUNCE_CYCLES-1; the toggle fires on the
  // cycle the count would reach DEBOUNCE_CYCLES.
  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    CARGA_A  = 3'd0,
    CARGA_B  = 3'd1,
    CARGA_OP = 3'd2,
    CALCULA  = 3'd3,
    MUESTRA  = 3'd4
  } estado_t;

  estado_t       r_estado;
  estado_t       w_sig;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_nivel;
  logic          r_nivel_d;
  logic [CW-1:0] r_cnt;
  logic          w_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_nivel   <= 1'b0;
      r_nivel_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= boton_enter;
      r_sync2   <= r_sync1;
      r_nivel_d <= r_nivel;
      if (r_sync2 == r_nivel) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_nivel <= ~r_nivel;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_press = r_nivel & ~r_nivel_d;

  always_ff @(posedge clk) begin
    if (reset) r_estado <= CARGA_A;
    else       r_estado <= w_sig;
  end

  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      CARGA_A:  if (w_press) w_sig = CARGA_B;
      CARGA_B:  if (w_press) w_sig = CARGA_OP;
      CARGA_OP: if (w_press) w_sig = CALCULA;
      CALCULA:  w_sig = MUESTRA;
      MUESTRA:  if (w_press) w_sig = CARGA_B;
      default:  w_sig = CARGA_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      op        <= '0;
      rdo_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      listo     <= 1'b0;
    end else begin
      case (r_estado)
        CARGA_A:  if (w_press) a <= entrada;
        CARGA_B:  if (w_press) b <= entrada;
        CARGA_OP: if (w_press) op <= entrada[5:0];
        CALCULA: begin
          rdo_reg   <= alu_rdo;
          carry_reg <= alu_carry;
          zero_reg  <= alu_zero;
          listo     <= 1'b1;
        end
        MUESTRA: begin
          if (w_press) begin
            a     <= entrada;
            listo <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign estado = r_estado;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Self-checking bench for secuenciador_alu: table of press vectors, hand-written
// debounce/latency/reset sequences, and randomized presses against a sequence model.
module tb_secuenciador_alu;

  logic       clk;
  logic       reset;
  logic [7:0] entrada;
  logic       boton_enter;
  logic [7:0] alu_rdo;
  logic       alu_carry;
  logic       alu_zero;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic [7:0] rdo_reg;
  logic       carry_reg;
  logic       zero_reg;
  logic       listo;
  logic [2:0] estado;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  secuenciador_alu #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .entrada(entrada), .boton_enter(boton_enter),
    .alu_rdo(alu_rdo), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .a(a), .b(b), .op(op), .rdo_reg(rdo_reg), .carry_reg(carry_reg),
    .zero_reg(zero_reg), .listo(listo), .estado(estado)
  );

  // Bench ALU: 8-bit add with carry out, zero flag on the 8-bit result.
  assign {alu_carry, alu_rdo} = {1'b0, a} + {1'b0, b};
  assign alu_zero = (alu_rdo == 8'h00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] entrada;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [5:0] eop;
    logic [7:0] erdo;
    logic       ec;
    logic       ez;
    logic       el;
    logic [2:0] est;
  } vec_t;

  vec_t tabla[6];

  // Sequence model: which load the next press performs, plus the visible registers.
  int unsigned m_fase;
  logic [7:0]  m_a, m_b, m_rdo;
  logic [5:0]  m_op;
  logic        m_c, m_z, m_l;

  function automatic logic [35:0] salidas();
    return {a, b, op, rdo_reg, carry_reg, zero_reg, listo, estado};
  endfunction

  function automatic logic [35:0] modelo();
    return {m_a, m_b, m_op, m_rdo, m_c, m_z, m_l, 3'(m_fase)};
  endfunction

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {a,b,op,rdo,c,z,listo,estado}=%h required %h", name, got, exp);
    end
  endtask

  task automatic modelo_reset();
    m_fase = 0; m_a = '0; m_b = '0; m_op = '0; m_rdo = '0;
    m_c = 1'b0; m_z = 1'b0; m_l = 1'b0;
  endtask

  task automatic modelo_press(input logic [7:0] val);
    int unsigned suma;
    case (m_fase)
      0: begin m_a = val; m_fase = 1; end
      1: begin m_b = val; m_fase = 2; end
      2: begin
        m_op  = val[5:0];
        suma  = int'(m_a) + int'(m_b);
        m_rdo = 8'(suma % 256);
        m_c   = (suma > 255);
        m_z   = ((suma % 256) == 0);
        m_l   = 1'b1;
        m_fase = 4;
      end
      default: begin m_a = val; m_l = 1'b0; m_fase = 1; end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulsar(input logic [7:0] val, input int unsigned hold);
    entrada = val;
    boton_enter = 1'b1;
    repeat (hold) @(negedge clk);
    boton_enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    entrada = '0;
    boton_enter = 1'b0;

    tabla[0] = '{8'h2A, 8'h2A, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1};
    tabla[1] = '{8'h15, 8'h2A, 8'h15, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2};
    tabla[2] = '{8'h20, 8'h2A, 8'h15, 6'h20, 8'h3F, 1'b0, 1'b0, 1'b1, 3'd4};
    tabla[3] = '{8'h01, 8'h01, 8'h15, 6'h20, 8'h3F, 1'b0, 1'b0, 1'b0, 3'd1};
    tabla[4] = '{8'hFF, 8'h01, 8'hFF, 6'h20, 8'h3F, 1'b0, 1'b0, 1'b0, 3'd2};
    tabla[5] = '{8'hE5, 8'h01, 8'hFF, 6'h25, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4};

    // Reset from power-up state
    @(negedge clk);
    do_reset();
    chk("reset", salidas(), 36'h0);

    // Table-driven press sequence
    for (int i = 0; i < 6; i++) begin
      pulsar(tabla[i].entrada, 6);
      chk($sformatf("tabla[%0d]", i), salidas(),
          {tabla[i].ea, tabla[i].eb, tabla[i].eop, tabla[i].erdo,
           tabla[i].ec, tabla[i].ez, tabla[i].el, tabla[i].est});
    end

    // Latency: press in CARGA_OP -> CALCULA next cycle, result one cycle later
    pulsar(8'h10, 6);
    pulsar(8'h20, 6);
    chk("pre_latencia", salidas(), {8'h10, 8'h20, 6'h25, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2});
    entrada = 8'h00;
    boton_enter = 1'b1;
    begin
      int unsigned k;
      k = 0;
      while (estado == 3'd2 && k < 30) begin
        @(negedge clk);
        k++;
      end
      if (k >= 30) chk("latencia_timeout", {33'h0, estado}, {33'h0, 3'd3});
    end
    chk("calcula_ciclo", salidas(), {8'h10, 8'h20, 6'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3});
    @(negedge clk);
    chk("muestra_ciclo", salidas(), {8'h10, 8'h20, 6'h00, 8'h30, 1'b0, 1'b0, 1'b1, 3'd4});
    repeat (6) @(negedge clk);
    boton_enter = 1'b0;
    repeat (10) @(negedge clk);
    chk("sostenido_muestra", salidas(), {8'h10, 8'h20, 6'h00, 8'h30, 1'b0, 1'b0, 1'b1, 3'd4});

    // Debounce thresholds
    do_reset();
    chk("reset_medio", salidas(), 36'h0);
    pulsar(8'h33, 3);
    chk("glitch_3", salidas(), 36'h0);
    pulsar(8'h11, 4);
    chk("pulso_4", salidas(), {8'h11, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1});
    pulsar(8'h22, 100);
    chk("sostenido_100", salidas(), {8'h11, 8'h22, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2});
    pulsar(8'h44, 1);
    chk("glitch_1", salidas(), {8'h11, 8'h22, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2});

    // Reset discards a partial load
    do_reset();
    pulsar(8'h77, 5);
    chk("carga_77", salidas(), {8'h77, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1});
    do_reset();
    chk("reset_tras_77", salidas(), 36'h0);
    pulsar(8'h05, 5);
    chk("carga_05", salidas(), {8'h05, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1});

    // Randomized presses and glitches against the sequence model
    do_reset();
    modelo_reset();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      pulsar(v, $urandom_range(12, 4));
      modelo_press(v);
      chk($sformatf("rand_press[%0d]", i), salidas(), modelo());
      if ($urandom_range(1, 0) == 1) begin
        pulsar(8'($urandom), $urandom_range(3, 1));
        chk($sformatf("rand_glitch[%0d]", i), salidas(), modelo());
      end
    end
    do_reset();
    chk("reset_final", salidas(), 36'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
